// File: rtl/clkgen_pkg.sv
// Shared definitions for the clock-domain controller: FSM encoding,
// parameter defaults and the saturating loss-counter helper.
package clkgen_pkg;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABLE    = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [1:0] ST_LOST      = 2'd3;

  typedef logic [1:0] state_t;

  localparam int LOCK_STABLE_DEF = 1024;
  localparam int DIV_RESET_DEF   = 0;
  localparam int LOSS_W          = 8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ce_divider.sv
// One clock-enable channel: divider register, phase counter and the
// registered strobe. The counter runs only in RUN; en gates the strobe only,
// so masking a channel never disturbs its phase.
module ce_divider #(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_run,
  input  logic             i_ce_ok,
  input  logic             i_we,
  input  logic [DIV_W-1:0] i_val,
  input  logic             i_en,
  output logic             o_ce
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             r_ce;

  // Divider register, loadable in any controller state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  r_div <= DIV_W'(DIV_RESET);
    else if (i_we) r_div <= i_val;
  end

  // Phase counter 0..D; a write restarts it and takes precedence over the wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            r_cnt <= '0;
    else if (!i_run)         r_cnt <= '0;
    else if (i_we)           r_cnt <= '0;
    else if (r_cnt == r_div) r_cnt <= '0;
    else                     r_cnt <= r_cnt + 1'b1;
  end

  // Strobe on phase 0; i_ce_ok drops in the last RUN cycle so nothing leaks into LOST.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_ce <= 1'b0;
    else          r_ce <= i_ce_ok && i_en && (r_cnt == '0);
  end

  assign o_ce = r_ce;

endmodule

// File: rtl/clk_domain_ctrl.sv
// PLL lock qualification and clock-enable generation.
//
// state      | meaning
// WAIT_LOCK  | waiting for synchronised lock; stability counter held at 0
// STABLE     | counting continuous lock cycles towards release
// RUN        | lock qualified: downstream reset released, strobes active
// LOST       | one cycle after lock dropped; bumps the loss counter
module clk_domain_ctrl
  import clkgen_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int DIV_W       = 8,
  parameter  int LOCK_STABLE = LOCK_STABLE_DEF,
  parameter  int DIV_RESET   = DIV_RESET_DEF,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pll_lock,
  input  logic              div_we,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [DIV_W-1:0]  div_val,
  input  logic [NUM_CH-1:0] en_mask,
  output logic [NUM_CH-1:0] ce_out,
  output logic              sys_reset_n,
  output logic              locked,
  output logic [LOSS_W-1:0] lock_loss_cnt
);

  localparam int STAB_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);

  logic              r_lock_meta;
  logic              r_lock_s;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [STAB_W-1:0] r_stab_cnt;
  logic              r_locked;
  logic [LOSS_W-1:0] r_loss_cnt;
  logic              w_run;
  logic              w_ce_ok;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Next-state decode for lock qualification.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT_LOCK: if (r_lock_s) w_state_nxt = ST_STABLE;
      ST_STABLE: begin
        if (!r_lock_s)                     w_state_nxt = ST_WAIT_LOCK;
        else if (r_stab_cnt == STAB_LAST)  w_state_nxt = ST_RUN;
      end
      ST_RUN:       if (!r_lock_s) w_state_nxt = ST_LOST;
      default:      w_state_nxt = ST_WAIT_LOCK;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_WAIT_LOCK;
    else          r_state <= w_state_nxt;
  end

  // Stability counter: counts only while in STABLE, so every entry starts from 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 r_stab_cnt <= '0;
    else if (r_state == ST_STABLE) r_stab_cnt <= r_stab_cnt + 1'b1;
    else                          r_stab_cnt <= '0;
  end

  // Lock indication registered from next state so it is high exactly in RUN cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_locked <= 1'b0;
    else          r_locked <= (w_state_nxt == ST_RUN);
  end

  // Lock-loss counter; reset is not a loss because only LOST increments it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               r_loss_cnt <= '0;
    else if (r_state == ST_LOST) r_loss_cnt <= sat_inc(r_loss_cnt);
  end

  assign w_run   = (r_state == ST_RUN);
  assign w_ce_ok = w_run && (w_state_nxt == ST_RUN);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic w_we;
    assign w_we = div_we && (div_ch == CH_W'(gi));

    ce_divider #(
      .DIV_W     (DIV_W),
      .DIV_RESET (DIV_RESET)
    ) u_div (
      .clock   (clock),
      .reset_n (reset_n),
      .i_run   (w_run),
      .i_ce_ok (w_ce_ok),
      .i_we    (w_we),
      .i_val   (div_val),
      .i_en    (en_mask[gi]),
      .o_ce    (ce_out[gi])
    );
  end

  assign locked        = r_locked;
  assign sys_reset_n   = r_locked;
  assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_clk_domain_ctrl.sv
// Directed bench for clk_domain_ctrl (NUM_CH=4, DIV_W=8, LOCK_STABLE=16)
// plus a 6-channel instance for out-of-range channel writes.
module tb_clk_domain_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pll_lock;
  logic       div_we;
  logic [1:0] div_ch;
  logic [7:0] div_val;
  logic [3:0] en_mask;
  logic [3:0] ce_out;
  logic       sys_reset_n;
  logic       locked;
  logic [7:0] lock_loss_cnt;

  logic       lock6;
  logic       we6;
  logic [2:0] ch6;
  logic [3:0] val6;
  logic [5:0] ce6;
  logic       sys6;
  logic       locked6;
  logic [7:0] loss6;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  clk_domain_ctrl #(
    .NUM_CH(4), .DIV_W(8), .LOCK_STABLE(16), .DIV_RESET(0)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .pll_lock(pll_lock),
    .div_we(div_we), .div_ch(div_ch), .div_val(div_val),
    .en_mask(en_mask), .ce_out(ce_out), .sys_reset_n(sys_reset_n),
    .locked(locked), .lock_loss_cnt(lock_loss_cnt)
  );

  clk_domain_ctrl #(
    .NUM_CH(6), .DIV_W(4), .LOCK_STABLE(4), .DIV_RESET(0)
  ) u_dut6 (
    .clock(clock), .reset_n(reset_n), .pll_lock(lock6),
    .div_we(we6), .div_ch(ch6), .div_val(val6),
    .en_mask(6'h3F), .ce_out(ce6), .sys_reset_n(sys6),
    .locked(locked6), .lock_loss_cnt(loss6)
  );

  typedef struct {
    logic [3:0] en;
    int         ph;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[13];
  int   d_tab[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_locked(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!locked && n <= limit);
  endtask

  task automatic wait_unlocked(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (locked && n <= limit);
  endtask

  function automatic logic [3:0] model_ce(input int ph);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ((ph % (d_tab[i] + 1)) == 0);
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ph;
    int early;
    int tmo;
    logic exp_bit;

    d_tab = '{0, 1, 3, 7};
    tbl[0]  = '{4'hF, 0, 4'hF};
    tbl[1]  = '{4'hF, 1, 4'h1};
    tbl[2]  = '{4'hF, 2, 4'h3};
    tbl[3]  = '{4'hF, 4, 4'h7};
    tbl[4]  = '{4'h5, 0, 4'h5};
    tbl[5]  = '{4'h5, 2, 4'h1};
    tbl[6]  = '{4'hA, 0, 4'hA};
    tbl[7]  = '{4'hA, 2, 4'h2};
    tbl[8]  = '{4'hA, 3, 4'h0};
    tbl[9]  = '{4'h8, 0, 4'h8};
    tbl[10] = '{4'h8, 4, 4'h0};
    tbl[11] = '{4'h0, 0, 4'h0};
    tbl[12] = '{4'hF, 0, 4'hF};

    reset_n = 1'b0; pll_lock = 1'b0; div_we = 1'b0; div_ch = '0; div_val = '0;
    en_mask = 4'hF;
    lock6 = 1'b1; we6 = 1'b0; ch6 = '0; val6 = '0;
    #2;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sys_reset_n", 32'(sys_reset_n), 0);
    chk("rst_ce_out", 32'(ce_out), 0);
    chk("rst_loss_cnt", 32'(lock_loss_cnt), 0);
    step(); step();
    reset_n = 1'b1;
    step();

    // Program dividers {0,1,3,7} while still waiting for lock.
    for (int i = 0; i < 4; i++) begin
      div_we = 1'b1; div_ch = 2'(i); div_val = 8'(d_tab[i]);
      step();
    end
    div_we = 1'b0;

    // Lock glitch during STABLE, then full requalification.
    early = 0;
    pll_lock = 1'b1;
    for (int i = 0; i < 12; i++) begin step(); if (locked) early = 1; end
    pll_lock = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); if (locked) early = 1; end
    pll_lock = 1'b1;
    wait_locked(40, n);
    chk("glitch_no_early_lock", 32'(early), 0);
    chk("requal_latency", 32'(n), 19);
    chk("run_sys_reset_n", 32'(sys_reset_n), 1);
    chk("first_cycle_ce_zero", 32'(ce_out), 0);
    chk("glitch_loss_cnt", 32'(lock_loss_cnt), 0);
    step();
    ph = 0;

    // Strobe periods 1,2,4,8 with all channels enabled.
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("periods_ph%0d", k), 32'(ce_out), 32'(model_ce(ph)));
      step();
      ph = (ph + 1) % 8;
    end

    // en_mask gates strobes without moving phase.
    for (int t = 0; t < 13; t++) begin
      en_mask = tbl[t].en;
      do begin
        step();
        ph = (ph + 1) % 8;
      end while (ph != tbl[t].ph);
      chk($sformatf("en_tbl%0d", t), 32'(ce_out), 32'(tbl[t].exp));
    end

    // Rewrite ch2 to D=5 on its wrap cycle (counter==3 when visible phase is 2 mod 4).
    while ((ph % 4) != 2) begin step(); ph = (ph + 1) % 8; end
    div_we = 1'b1; div_ch = 2'd2; div_val = 8'd5;
    step();
    div_we = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      exp_bit = (k >= 2) && (((k - 2) % 6) == 0);
      chk($sformatf("ch2_rewrite_k%0d", k), 32'(ce_out[2]), 32'(exp_bit));
      step();
    end

    // Lock loss in RUN.
    pll_lock = 1'b0;
    wait_unlocked(10, n);
    chk("loss_latency_le3", 32'((n >= 1) && (n <= 3)), 1);
    chk("loss_sys_reset_n", 32'(sys_reset_n), 0);
    chk("loss_ce_out", 32'(ce_out), 0);
    step();
    chk("loss_cnt_1", 32'(lock_loss_cnt), 1);

    // Many more losses: counter saturates.
    tmo = 0;
    for (int l = 1; l < 300; l++) begin
      pll_lock = 1'b1;
      wait_locked(40, n);
      if (n > 40) tmo++;
      pll_lock = 1'b0;
      wait_unlocked(10, n);
      if (n > 10) tmo++;
    end
    step(); step();
    chk("loss_loop_timeouts", 32'(tmo), 0);
    chk("loss_cnt_saturated", 32'(lock_loss_cnt), 255);

    // Reset pulse during RUN with lock held high.
    pll_lock = 1'b1;
    wait_locked(40, n);
    chk("relock_latency", 32'(n), 19);
    step(); step();
    reset_n = 1'b0;
    #2;
    chk("async_rst_locked", 32'(locked), 0);
    chk("async_rst_sys_reset_n", 32'(sys_reset_n), 0);
    chk("async_rst_ce_out", 32'(ce_out), 0);
    chk("async_rst_loss_cnt", 32'(lock_loss_cnt), 0);
    step();
    reset_n = 1'b1;
    wait_locked(40, n);
    chk("post_rst_requal_latency", 32'(n), 19);
    step();
    chk("post_rst_ce_a", 32'(ce_out), 32'hF);
    step();
    chk("post_rst_ce_b_divreset", 32'(ce_out), 32'hF);
    chk("post_rst_loss_cnt", 32'(lock_loss_cnt), 0);

    // Six-channel instance: writes to channels 6 and 7 are ignored.
    n = 0;
    while (!locked6 && n < 20) begin step(); n++; end
    chk("dut6_locked", 32'(locked6), 1);
    chk("dut6_sys_reset_n", 32'(sys6), 1);
    chk("dut6_loss_cnt", 32'(loss6), 0);
    we6 = 1'b1; ch6 = 3'd6; val6 = 4'd3;
    step();
    ch6 = 3'd7;
    step();
    we6 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("dut6_invalid_k%0d", k), 32'(ce6), 32'h3F);
      step();
    end
    we6 = 1'b1; ch6 = 3'd5; val6 = 4'd1;
    step();
    we6 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      exp_bit = (k == 1) || ((k % 2) == 0);
      chk($sformatf("dut6_ch5_k%0d", k), 32'(ce6), 32'({exp_bit, 5'h1F}));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
